// File: rtl/reflet_sleep_ctrl.sv
// reflet_sleep_ctrl: byte-bus sleep controller gating cpu_enable until an
// unmasked external interrupt or the programmable wake timer fires.
module reflet_sleep_ctrl #(
    parameter int                        base_addr_size = 15,
    parameter logic [base_addr_size-1:0] base_addr      = 15'h7F10,
    parameter int                        clk_freq       = 1000000,
    parameter int                        tick_freq      = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic [7:0]                data_in,
    input  logic                      write_en,
    output logic [7:0]                data_out,
    input  logic [3:0]                ext_int,
    output logic                      cpu_enable,
    output logic                      wake_int
);
    localparam int DIV = clk_freq / tick_freq;
    localparam int PW  = $clog2(DIV + 1);

    typedef enum logic [1:0] {RUN, SLEEP, WAKE} state_t;

    state_t                    state_q, state_d;
    logic                      tmr_en_q, tmr_en_d;
    logic [3:0]                mask_q, mask_d;
    logic [15:0]               tmr_q, tmr_d, cnt_q, cnt_d;
    logic [7:0]                status_q, status_d, dout_q, dout_d;
    logic [PW-1:0]             presc_q, presc_d;
    logic [base_addr_size-1:0] off;
    logic [7:0]                status_set, status_clr, rd;
    logic [3:0]                ext_hit;
    logic                      hit, wr, tick, wake_tmr, wake_ext;

    always_comb begin
        off        = addr - base_addr;
        hit        = enable && off <= base_addr_size'(4);
        wr         = hit && write_en && state_q == RUN;
        tick       = presc_q == PW'(DIV - 1);
        ext_hit    = ext_int & mask_q;
        wake_ext   = |ext_hit;
        // a tick that brings the counter to zero wakes in the same cycle
        wake_tmr   = tmr_en_q && (cnt_q == 16'd0 || (tick && cnt_q == 16'd1));
        state_d    = state_q;
        tmr_en_d   = tmr_en_q;
        mask_d     = mask_q;
        tmr_d      = tmr_q;
        cnt_d      = cnt_q;
        presc_d    = presc_q;
        status_set = 8'h00;
        status_clr = 8'h00;
        case (state_q)
            RUN: begin
                if (wr && off[2:0] == 3'd0 && data_in[0]) begin
                    if (mask_q == 4'd0 && !data_in[1]) begin
                        status_set[2] = 1'b1;
                    end else begin
                        cnt_d   = tmr_q;
                        presc_d = '0;
                        state_d = SLEEP;
                    end
                end
            end
            SLEEP: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick && tmr_en_q && cnt_q != 16'd0) cnt_d = cnt_q - 1'b1;
                if (wake_tmr || wake_ext) begin
                    state_d    = WAKE;
                    status_set = {ext_hit, 2'b00, wake_ext, wake_tmr};
                end
            end
            default: state_d = RUN;
        endcase
        if (wr) begin
            case (off[2:0])
                3'd0:    tmr_en_d = data_in[1];
                3'd1:    mask_d = data_in[3:0];
                3'd2:    tmr_d[7:0] = data_in;
                3'd3:    tmr_d[15:8] = data_in;
                default: status_clr = data_in;
            endcase
        end
        status_d = (status_q & ~status_clr) | status_set;
        rd = off[2:0] == 3'd0 ? {6'b0, tmr_en_q, state_q == SLEEP} :
             off[2:0] == 3'd1 ? {4'b0, mask_q} :
             off[2:0] == 3'd2 ? tmr_q[7:0] :
             off[2:0] == 3'd3 ? tmr_q[15:8] : status_q;
        dout_d = hit ? rd : 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            tmr_en_q <= 1'b0;
            mask_q   <= '0;
            tmr_q    <= '0;
            cnt_q    <= '0;
            presc_q  <= '0;
            status_q <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            tmr_en_q <= tmr_en_d;
            mask_q   <= mask_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            presc_q  <= presc_d;
            status_q <= status_d;
            dout_q   <= dout_d;
        end
    end

    assign data_out   = dout_q;
    assign cpu_enable = state_q == RUN;
    assign wake_int   = state_q == WAKE;
endmodule

// File: tb/tb_reflet_sleep_ctrl.sv
// tb_reflet_sleep_ctrl: register vector table plus directed sleep/wake
// sequences; bus reads are checked through an expected-value queue.
module tb_reflet_sleep_ctrl;
    localparam logic [14:0] BASE = 15'h7F10;

    logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, write_en = 1'b0;
    logic [14:0] addr = '0;
    logic [7:0]  data_in = '0, data_out;
    logic [3:0]  ext_int = '0;
    logic        cpu_enable, wake_int;

    int checks = 0, failures = 0, wake_cnt = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [14:0] a;
        logic [7:0]  wd;
        logic        we;
        logic [7:0]  exp;
    } vec_t;
    vec_t v[10];

    reflet_sleep_ctrl #(.base_addr_size(15), .base_addr(BASE), .clk_freq(10), .tick_freq(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr), .data_in(data_in),
        .write_en(write_en), .data_out(data_out), .ext_int(ext_int),
        .cpu_enable(cpu_enable), .wake_int(wake_int));

    always #5 clk = ~clk;
    always @(negedge clk) if (wake_int) wake_cnt++;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [14:0] a, input logic [7:0] d);
        @(negedge clk);
        enable = 1'b1; write_en = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        enable = 1'b0; write_en = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [14:0] a, input logic [7:0] exp);
        @(negedge clk);
        enable = 1'b1; addr = a;
        sb.push_back(exp);
        @(negedge clk);
        enable = 1'b0;
        chk(nm, data_out, sb.pop_front());
    endtask

    initial begin
        int n, w0;
        v[0] = '{BASE + 15'd1, 8'h0F, 1'b1, 8'h0F};
        v[1] = '{BASE + 15'd1, 8'hF5, 1'b1, 8'h05};
        v[2] = '{BASE + 15'd2, 8'hA5, 1'b1, 8'hA5};
        v[3] = '{BASE + 15'd3, 8'h3C, 1'b1, 8'h3C};
        v[4] = '{BASE,         8'h02, 1'b1, 8'h02};
        v[5] = '{BASE,         8'h00, 1'b1, 8'h00};
        v[6] = '{BASE + 15'd4, 8'h00, 1'b0, 8'h00};
        v[7] = '{BASE + 15'd5, 8'hFF, 1'b1, 8'h00};
        v[8] = '{BASE - 15'd1, 8'hFF, 1'b1, 8'h00};
        v[9] = '{BASE + 15'd1, 8'h00, 1'b1, 8'h00};

        #12;
        chk("reset_cpu_enable", {7'b0, cpu_enable}, 8'h01);
        chk("reset_wake_int", {7'b0, wake_int}, 8'h00);
        chk("reset_data_out", data_out, 8'h00);
        @(negedge clk) reset = 1'b1;

        foreach (v[i]) begin
            if (v[i].we) wr(v[i].a, v[i].wd);
            rd($sformatf("vec%0d", i), v[i].a, v[i].exp);
        end

        // external wake
        wr(BASE + 15'd1, 8'h04);
        wr(BASE, 8'h01);
        chk("ext_sleep_entry", {7'b0, cpu_enable}, 8'h00);
        rd("ext_ctrl_asleep", BASE, 8'h01);
        repeat (50) @(negedge clk);
        chk("ext_still_asleep", {7'b0, cpu_enable}, 8'h00);
        ext_int = 4'b0100;
        @(negedge clk);
        chk("ext_wake_pulse", {6'b0, cpu_enable, wake_int}, 8'h01);
        ext_int = 4'b0000;
        @(negedge clk);
        chk("ext_run_again", {6'b0, cpu_enable, wake_int}, 8'h02);
        rd("ext_status", BASE + 15'd4, 8'h42);
        wr(BASE + 15'd4, 8'hFF);

        // masked line must not wake
        wr(BASE, 8'h01);
        w0 = wake_cnt;
        ext_int = 4'b0001;
        repeat (100) @(negedge clk);
        chk("masked_asleep", {7'b0, cpu_enable}, 8'h00);
        chk("masked_no_pulse", 8'(wake_cnt - w0), 8'h00);
        rd("masked_status", BASE + 15'd4, 8'h00);
        ext_int = 4'b0101;
        n = 0;
        while (!cpu_enable && n < 20) begin @(negedge clk); n++; end
        ext_int = 4'b0000;
        chk("masked_release", {7'b0, cpu_enable}, 8'h01);
        rd("masked_release_status", BASE + 15'd4, 8'h42);
        wr(BASE + 15'd4, 8'hFF);

        // timer wake: 3 ticks of 10 clocks
        wr(BASE + 15'd1, 8'h00);
        wr(BASE + 15'd2, 8'h03);
        wr(BASE + 15'd3, 8'h00);
        w0 = wake_cnt;
        wr(BASE, 8'h03);
        n = 0;
        while (!cpu_enable && n < 200) begin n++; @(negedge clk); end
        chk("tmr_low_cycles", 8'(n), 8'd31);
        chk("tmr_one_pulse", 8'(wake_cnt - w0), 8'h01);
        rd("tmr_status", BASE + 15'd4, 8'h01);
        rd("tmr_ctrl_after", BASE, 8'h02);
        wr(BASE + 15'd4, 8'hFF);

        // simultaneous wake on first sleep cycle
        wr(BASE + 15'd2, 8'h00);
        wr(BASE + 15'd1, 8'h04);
        ext_int = 4'b0100;
        repeat (3) @(negedge clk);
        chk("sim_run_before", {7'b0, cpu_enable}, 8'h01);
        wr(BASE, 8'h03);
        chk("sim_sleep", {6'b0, cpu_enable, wake_int}, 8'h00);
        @(negedge clk);
        chk("sim_wake", {6'b0, cpu_enable, wake_int}, 8'h01);
        ext_int = 4'b0000;
        @(negedge clk);
        chk("sim_run", {7'b0, cpu_enable}, 8'h01);
        rd("sim_status", BASE + 15'd4, 8'h43);
        wr(BASE + 15'd4, 8'hFF);
        rd("sim_status_clr", BASE + 15'd4, 8'h00);

        // no wake source
        wr(BASE, 8'h00);
        wr(BASE + 15'd1, 8'h00);
        wr(BASE, 8'h01);
        chk("err_stays_run", {7'b0, cpu_enable}, 8'h01);
        rd("err_status", BASE + 15'd4, 8'h04);
        rd("err_ctrl", BASE, 8'h00);
        rd("undecoded", BASE + 15'd6, 8'h00);

        // async reset mid-sleep
        wr(BASE + 15'd1, 8'h04);
        wr(BASE, 8'h01);
        repeat (5) @(negedge clk);
        chk("pre_reset_asleep", {7'b0, cpu_enable}, 8'h00);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_cpu_enable", {7'b0, cpu_enable}, 8'h01);
        chk("async_reset_data_out", data_out, 8'h00);
        @(negedge clk) reset = 1'b1;
        rd("post_reset_mask", BASE + 15'd1, 8'h00);
        rd("post_reset_status", BASE + 15'd4, 8'h00);
        rd("post_reset_ctrl", BASE, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
